// File: rtl/riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_core
// Brief    : FSM-sequenced RV-subset core, serial imem load, optional MUL (RV_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle_core #(
   parameter int XLEN    = 64,
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ins_write,
   input  logic [31:0]     instruction_in,
   output logic [XLEN-1:0] res,
   output logic            retire,
   output logic            halted,
   output logic [XLEN-1:0] pc_out
);

   localparam int SHW = $clog2(XLEN);
   localparam int BSH = $clog2(XLEN / 8);
   localparam logic [6:0] OP_LD  = 7'h03;
   localparam logic [6:0] OP_I   = 7'h13;
   localparam logic [6:0] OP_SD  = 7'h23;
   localparam logic [6:0] OP_R   = 7'h33;
   localparam logic [6:0] OP_BR  = 7'h63;
   localparam logic [6:0] OP_JAL = 7'h6F;
   localparam logic [6:0] OP_SYS = 7'h73;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t             state_q;
   logic [XLEN-1:0]    pc_q, a_q, b_q, imm_q, alu_q, mdr_q, res_q;
   logic [31:0]        ir_q;
   logic               retire_q, halted_q;
   logic [IMEM_AW-1:0] wptr_q;
   logic [31:0]        imem_q [2**IMEM_AW];
   logic [XLEN-1:0]    regs_q [32];
   logic [XLEN-1:0]    dmem_q [2**DMEM_AW];

   logic [6:0]         opcode, funct7;
   logic [2:0]         funct3;
   logic [4:0]         rd, rs1, rs2;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]    imm_d, op2, alu_d, pc_plus4, wb_val;
   logic [SHW-1:0]     shamt;
   logic [DMEM_AW-1:0] dmem_idx;
   logic               alu_ok, is_r, f7_std, f7_alt, br_taken;

   assign opcode   = ir_q[6:0];
   assign rd       = ir_q[11:7];
   assign funct3   = ir_q[14:12];
   assign rs1      = ir_q[19:15];
   assign rs2      = ir_q[24:20];
   assign funct7   = ir_q[31:25];
   assign imm_d    = XLEN'(imm32);
   assign pc_plus4 = pc_q + XLEN'(4);
   assign br_taken = (a_q == b_q) ^ funct3[0];
   assign wb_val   = (opcode == OP_LD) ? mdr_q : alu_q;
   assign dmem_idx = alu_q[DMEM_AW+BSH-1:BSH];

   assign res    = ins_write ? '0 : res_q;
   assign retire = retire_q & ~ins_write;
   assign halted = halted_q & ~ins_write;
   assign pc_out = pc_q;

   always_comb begin
      case (opcode)
         OP_SD:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         OP_BR:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
         OP_JAL:  imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
         default: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      endcase
   end

   // For I-type the funct7 field is immediate bits and must not qualify the op.
   always_comb begin
      is_r   = (opcode == OP_R);
      f7_std = (funct7 == 7'b0000000);
      f7_alt = (funct7 == 7'b0100000);
      op2    = is_r ? b_q : imm_q;
      shamt  = b_q[SHW-1:0];
      alu_d  = '0;
      alu_ok = 1'b0;
      case (funct3)
         3'b000: begin
            if (!is_r || f7_std) begin
               alu_d  = a_q + op2;
               alu_ok = 1'b1;
            end else if (f7_alt) begin
               alu_d  = a_q - op2;
               alu_ok = 1'b1;
            end
`ifdef RV_MUL_EN
            else if (funct7 == 7'b0000001) begin
               alu_d  = a_q * b_q;
               alu_ok = 1'b1;
            end
`endif
         end
         3'b001: if (is_r && f7_std) begin alu_d = a_q << shamt; alu_ok = 1'b1; end
         3'b010: if (!is_r || f7_std) begin
            alu_d  = XLEN'($signed(a_q) < $signed(op2));
            alu_ok = 1'b1;
         end
         3'b100: if (!is_r || f7_std) begin alu_d = a_q ^ op2; alu_ok = 1'b1; end
         3'b101: begin
            if (is_r && f7_std) begin
               alu_d  = a_q >> shamt;
               alu_ok = 1'b1;
            end else if (is_r && f7_alt) begin
               alu_d  = $unsigned($signed(a_q) >>> shamt);
               alu_ok = 1'b1;
            end
         end
         3'b110: if (!is_r || f7_std) begin alu_d = a_q | op2; alu_ok = 1'b1; end
         3'b111: if (!is_r || f7_std) begin alu_d = a_q & op2; alu_ok = 1'b1; end
         default: ;
      endcase
   end

   // Program memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (ins_write) imem_q[wptr_q] <= instruction_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
         res_q    <= '0;
         retire_q <= 1'b0;
         halted_q <= 1'b0;
         wptr_q   <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         for (int i = 0; i < 2**DMEM_AW; i++) dmem_q[i] <= '0;
      end else if (ins_write) begin
         wptr_q   <= wptr_q + 1'b1;
         pc_q     <= '0;
         state_q  <= S_FETCH;
         retire_q <= 1'b0;
         halted_q <= 1'b0;
         res_q    <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               ir_q    <= imem_q[pc_q[IMEM_AW+1:2]];
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               a_q   <= regs_q[rs1];
               b_q   <= regs_q[rs2];
               imm_q <= imm_d;
               if (opcode == OP_SYS) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                  retire_q <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               state_q <= S_FETCH;
               if ((opcode == OP_R || opcode == OP_I) && alu_ok) begin
                  alu_q   <= alu_d;
                  state_q <= S_WB;
               end else if (opcode == OP_LD || opcode == OP_SD) begin
                  alu_q   <= a_q + imm_q;
                  state_q <= S_MEM;
               end else if (opcode == OP_JAL) begin
                  alu_q   <= pc_plus4;
                  state_q <= S_WB;
               end else begin
                  // Branches, and anything unrecognised, retire here as NOPs.
                  pc_q     <= (opcode == OP_BR && funct3[2:1] == 2'b00 && br_taken) ?
                              pc_q + imm_q : pc_plus4;
                  retire_q <= 1'b1;
               end
            end
            S_MEM: begin
               if (opcode == OP_SD) begin
                  dmem_q[dmem_idx] <= b_q;
                  pc_q             <= pc_plus4;
                  retire_q         <= 1'b1;
                  state_q          <= S_FETCH;
               end else begin
                  mdr_q   <= dmem_q[dmem_idx];
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               if (rd != 5'd0) begin
                  regs_q[rd] <= wb_val;
                  res_q      <= wb_val;
               end
               pc_q     <= (opcode == OP_JAL) ? pc_q + imm_q : pc_plus4;
               retire_q <= 1'b1;
               state_q  <= S_FETCH;
            end
            S_HALT:  halted_q <= 1'b1;
            default: state_q <= S_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle_core
// Brief    : Scoreboard bench: expected retire events queued per program, popped on retire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_core;

   logic        clk, rst, ins_write;
   logic [31:0] instruction_in;
   logic [63:0] res, pc_out;
   logic        retire, halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] res;
      logic [63:0] pc;
      int          gap;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] prog[$];

   riscv_multicycle_core #(.XLEN(64), .IMEM_AW(8), .DMEM_AW(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .ins_write      (ins_write),
      .instruction_in (instruction_in),
      .res            (res),
      .retire         (retire),
      .halted         (halted),
      .pc_out         (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_i(input int op, input int f3, input int rd,
                                         input int rs1, input int imm);
      logic [31:0] o = op, f = f3, d = rd, s = rs1, m = imm;
      return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                         input int rs1, input int rs2);
      logic [31:0] g = f7, f = f3, d = rd, s = rs1, t = rs2;
      return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
      logic [31:0] t = rs2, s = rs1, m = imm;
      return {m[11:5], t[4:0], s[4:0], 3'b011, m[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
      logic [31:0] f = f3, s = rs1, t = rs2, m = imm;
      return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int rd, input int imm);
      logic [31:0] d = rd, m = imm;
      return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(7'h13, 0, rd, rs1, imm);
   endfunction

   localparam logic [31:0] ECALL = 32'h0000_0073;

   task automatic exp_ret(input logic [63:0] r, input int p, input int g);
      exp_t e;
      e.res = r;
      e.pc  = 64'(p);
      e.gap = g;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      ins_write      = 1'b0;
      instruction_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic load_prog();
      foreach (prog[i]) begin
         @(negedge clk);
         ins_write      = 1'b1;
         instruction_in = prog[i];
      end
      @(negedge clk);
      ins_write      = 1'b0;
      instruction_in = '0;
   endtask

   task automatic run_prog(input string tag, input int budget);
      int   gap = 0;
      int   n   = 0;
      exp_t e;
      while (n < budget && halted !== 1'b1) begin
         @(negedge clk);
         gap++;
         n++;
         if (retire === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL %s extra_retire: got pc=%h, required no retire", tag, pc_out);
            end else begin
               e = sbq.pop_front();
               checks++;
               if (res !== e.res) begin
                  errors++;
                  $display("FAIL %s res@pc%0d: got %h, required %h", tag, e.pc, res, e.res);
               end
               checks++;
               if (pc_out !== e.pc) begin
                  errors++;
                  $display("FAIL %s pc: got %h, required %h", tag, pc_out, e.pc);
               end
               checks++;
               if (gap != e.gap) begin
                  errors++;
                  $display("FAIL %s latency@pc%0d: got %0d, required %0d", tag, e.pc, gap, e.gap);
               end
            end
            gap = 0;
         end
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL %s halt_timeout: got halted=%b, required 1", tag, halted);
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL %s missing_retires: got %0d left, required 0", tag, sbq.size());
      end
      sbq.delete();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (retire !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt_hold: got retire=%b halted=%b, required 0/1", tag, retire, halted);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ins_write = 1'b0;
      instruction_in = '0;
      #1;
      do_reset();
      checks++;
      if (res !== 64'd0 || retire !== 1'b0 || halted !== 1'b0 || pc_out !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs: got res=%h retire=%b halted=%b pc=%h, required all 0",
                  res, retire, halted, pc_out);
      end
   endtask

   task automatic test_addi_add();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, 5));
      prog.push_back(addi(2, 0, -3));
      prog.push_back(enc_r(0, 0, 3, 1, 2));
      prog.push_back(ECALL);
      exp_ret(64'd5, 4, 4);
      exp_ret(64'hFFFF_FFFF_FFFF_FFFD, 8, 4);
      exp_ret(64'd2, 12, 4);
      exp_ret(64'd2, 12, 2);
      load_prog();
      run_prog("addi_add", 40);
   endtask

   task automatic test_alu();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, -3));             exp_ret(64'hFFFF_FFFF_FFFF_FFFD, 4, 4);
      prog.push_back(addi(2, 0, 5));              exp_ret(64'd5, 8, 4);
      prog.push_back(addi(7, 0, 65));             exp_ret(64'd65, 12, 4);
      prog.push_back(enc_r(32, 0, 3, 1, 2));      exp_ret(64'hFFFF_FFFF_FFFF_FFF8, 16, 4);
      prog.push_back(enc_r(0, 7, 4, 1, 2));       exp_ret(64'd5, 20, 4);
      prog.push_back(enc_r(0, 6, 4, 1, 2));       exp_ret(64'hFFFF_FFFF_FFFF_FFFD, 24, 4);
      prog.push_back(enc_r(0, 4, 4, 1, 2));       exp_ret(64'hFFFF_FFFF_FFFF_FFF8, 28, 4);
      prog.push_back(enc_r(0, 2, 4, 1, 2));       exp_ret(64'd1, 32, 4);
      prog.push_back(enc_r(0, 2, 4, 2, 1));       exp_ret(64'd0, 36, 4);
      prog.push_back(enc_r(0, 1, 4, 2, 2));       exp_ret(64'd160, 40, 4);
      prog.push_back(enc_r(0, 1, 4, 2, 7));       exp_ret(64'd10, 44, 4);
      prog.push_back(enc_r(0, 5, 4, 1, 2));       exp_ret(64'h07FF_FFFF_FFFF_FFFF, 48, 4);
      prog.push_back(enc_r(32, 5, 4, 1, 2));      exp_ret(64'hFFFF_FFFF_FFFF_FFFF, 52, 4);
      prog.push_back(enc_i(7'h13, 7, 4, 1, 15));  exp_ret(64'hD, 56, 4);
      prog.push_back(enc_i(7'h13, 6, 4, 2, -16)); exp_ret(64'hFFFF_FFFF_FFFF_FFF5, 60, 4);
      prog.push_back(enc_i(7'h13, 4, 4, 2, 1));   exp_ret(64'd4, 64, 4);
      prog.push_back(enc_i(7'h13, 2, 4, 1, -2));  exp_ret(64'd1, 68, 4);
      prog.push_back(enc_i(7'h13, 2, 4, 2, 5));   exp_ret(64'd0, 72, 4);
      prog.push_back(enc_r(32, 4, 4, 1, 2));      exp_ret(64'd0, 76, 3);
      prog.push_back(32'h0000_007F);              exp_ret(64'd0, 80, 3);
      prog.push_back(ECALL);                      exp_ret(64'd0, 80, 2);
      load_prog();
      run_prog("alu", 200);
   endtask

   task automatic test_sd_ld();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, 127));
      prog.push_back(enc_s(1, 0, 16));
      prog.push_back(addi(1, 0, 1));
      prog.push_back(enc_i(7'h03, 3, 2, 0, 16));
      prog.push_back(ECALL);
      exp_ret(64'h7F, 4, 4);
      exp_ret(64'h7F, 8, 4);
      exp_ret(64'd1, 12, 4);
      exp_ret(64'h7F, 16, 5);
      exp_ret(64'h7F, 16, 2);
      load_prog();
      run_prog("sd_ld", 60);
      checks++;
      if (dut.dmem_q[2] !== 64'h7F) begin
         errors++;
         $display("FAIL sd_ld dmem2: got %h, required %h", dut.dmem_q[2], 64'h7F);
      end
   endtask

   task automatic test_branch();
      do_reset();
      prog.delete();
      prog.push_back(enc_b(0, 0, 0, 8));
      prog.push_back(addi(5, 0, 1));
      prog.push_back(enc_b(1, 0, 0, 8));
      prog.push_back(addi(6, 0, 3));
      prog.push_back(enc_b(1, 6, 0, 8));
      prog.push_back(addi(5, 0, 1));
      prog.push_back(ECALL);
      exp_ret(64'd0, 8, 3);
      exp_ret(64'd0, 12, 3);
      exp_ret(64'd3, 16, 4);
      exp_ret(64'd3, 24, 3);
      exp_ret(64'd3, 24, 2);
      load_prog();
      run_prog("branch", 60);
      checks++;
      if (dut.regs_q[5] !== 64'd0) begin
         errors++;
         $display("FAIL branch x5: got %h, required 0", dut.regs_q[5]);
      end
   endtask

   task automatic test_jal_x0();
      do_reset();
      prog.delete();
      prog.push_back(addi(2, 0, 1));
      prog.push_back(enc_j(1, 12));
      prog.push_back(addi(5, 0, 1));
      prog.push_back(addi(5, 0, 1));
      prog.push_back(addi(0, 0, 9));
      prog.push_back(ECALL);
      exp_ret(64'd1, 4, 4);
      exp_ret(64'd8, 16, 4);
      exp_ret(64'd8, 20, 4);
      exp_ret(64'd8, 20, 2);
      load_prog();
      run_prog("jal_x0", 60);
      checks++;
      if (dut.regs_q[0] !== 64'd0 || dut.regs_q[1] !== 64'd8 || dut.regs_q[5] !== 64'd0) begin
         errors++;
         $display("FAIL jal_x0 regs: got x0=%h x1=%h x5=%h, required 0/8/0",
                  dut.regs_q[0], dut.regs_q[1], dut.regs_q[5]);
      end
   endtask

   task automatic test_abort();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, 85));
      prog.push_back(enc_s(1, 0, 8));
      prog.push_back(ECALL);
      load_prog();
      repeat (7) @(negedge clk);
      checks++;
      if (pc_out !== 64'd4 || res !== 64'h55) begin
         errors++;
         $display("FAIL abort pre: got pc=%h res=%h, required 4/55", pc_out, res);
      end
      ins_write      = 1'b1;
      instruction_in = ECALL;
      #1;
      checks++;
      if (res !== 64'd0) begin
         errors++;
         $display("FAIL abort res_in_load: got %h, required 0", res);
      end
      @(negedge clk);
      checks++;
      if (pc_out !== 64'd0 || retire !== 1'b0 || dut.dmem_q[1] !== 64'd0) begin
         errors++;
         $display("FAIL abort post: got pc=%h retire=%b dmem1=%h, required 0/0/0",
                  pc_out, retire, dut.dmem_q[1]);
      end
      ins_write      = 1'b0;
      instruction_in = '0;
   endtask

   task automatic test_reset_mid_ld();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, 51));
      prog.push_back(enc_s(1, 0, 0));
      prog.push_back(enc_i(7'h03, 3, 2, 0, 0));
      prog.push_back(ECALL);
      load_prog();
      repeat (10) @(negedge clk);
      checks++;
      if (pc_out !== 64'd8 || dut.dmem_q[0] !== 64'h33) begin
         errors++;
         $display("FAIL rst_ld pre: got pc=%h dmem0=%h, required 8/33", pc_out, dut.dmem_q[0]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (res !== 64'd0 || retire !== 1'b0 || halted !== 1'b0 || pc_out !== 64'd0 ||
          dut.dmem_q[0] !== 64'd0 || dut.regs_q[1] !== 64'd0) begin
         errors++;
         $display("FAIL rst_ld cleared: got res=%h ret=%b halt=%b pc=%h dmem0=%h x1=%h, required 0",
                  res, retire, halted, pc_out, dut.dmem_q[0], dut.regs_q[1]);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_ret(64'h33, 4, 4);
      exp_ret(64'h33, 8, 4);
      exp_ret(64'h33, 12, 5);
      exp_ret(64'h33, 12, 2);
      run_prog("rst_restart", 60);
   endtask

   task automatic test_mul();
      do_reset();
      prog.delete();
      prog.push_back(addi(1, 0, 6));
      prog.push_back(addi(2, 0, -7));
      prog.push_back(enc_r(1, 0, 3, 1, 2));
      prog.push_back(ECALL);
      exp_ret(64'd6, 4, 4);
      exp_ret(64'hFFFF_FFFF_FFFF_FFF9, 8, 4);
`ifdef RV_MUL_EN
      exp_ret(64'hFFFF_FFFF_FFFF_FFD6, 12, 4);
      exp_ret(64'hFFFF_FFFF_FFFF_FFD6, 12, 2);
`else
      exp_ret(64'hFFFF_FFFF_FFFF_FFF9, 12, 3);
      exp_ret(64'hFFFF_FFFF_FFFF_FFF9, 12, 2);
`endif
      load_prog();
      run_prog("mul", 60);
   endtask

   initial begin
      test_reset();
      test_addi_add();
      test_alu();
      test_sd_ld();
      test_branch();
      test_jal_x0();
      test_abort();
      test_reset_mid_ld();
      test_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
